// File: rtl/qspi_pkg.sv
// qspi_pkg: definitions shared by the QSPI flash arbiter and the QSPI controller.
//   - ARB_* : 2-bit arbiter FSM state encodings.
//   - QSPI_*_WIDTH : default command/address/data widths, shared with the controller.
package qspi_pkg;

  localparam int unsigned QSPI_ADDRESS_WIDTH = 32;
  localparam int unsigned QSPI_COMMAND_WIDTH = 8;
  localparam int unsigned QSPI_DATA_WIDTH    = 4;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;
  localparam logic [1:0] ARB_RESP  = 2'd3;

endpackage

// File: rtl/qspi_rr_arbiter.sv
// qspi_rr_arbiter: purely combinational round-robin pick.
// The search starts just after the previous owner, so the requester after i_last wins first.
// Ports:
//   i_valid    [NUM_REQ]   request vector
//   i_last     [ID_WIDTH]  index of the previous owner (the pointer register lives in the parent)
//   o_grant    [NUM_REQ]   one-hot winner (all zero when nothing is requested)
//   o_grant_id [ID_WIDTH]  index of the winner
//   o_any      1           at least one request is pending
module qspi_rr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_valid,
  input  logic [ID_WIDTH-1:0] i_last,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_grant_id,
  output logic                o_any
);

  int unsigned w_dist;
  int unsigned w_best;

  // Distance of requester i from the pointer: last+1 has distance 0. The smallest wins.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    w_dist     = 0;
    w_best     = NUM_REQ;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 32'(i_last) - 1) % NUM_REQ;
      if (i_valid[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_grant_id = ID_WIDTH'(i);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qspi_flash_arbiter.sv
// qspi_flash_arbiter: shares one QSPI controller between NUM_REQ requesters.
// A round-robin winner is accepted in IDLE, and its payload is latched onto the ctl_* outputs.
// A one-cycle start is issued, the arbiter waits for done, then the read data is returned
// as a one-cycle response to the owner.
// Optional macro QSPI_ARB_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT_CYCLES cycles. On expiry
// the response carries o_rsp_err=1 and o_rsp_data=0.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake (ready is one-hot, only in IDLE)
//   i_req_cmd/addr/wdata  packed payloads, requester i at [i*W +: W]
//   o_rsp_valid           one-hot response pulse; o_rsp_data/o_rsp_err shared
//   o_grant_id            current or last owner
//   o_ctl_start/command/address/data_in  controller request side
//   i_ctl_data_out/busy/done             controller response side
module qspi_flash_arbiter
  import qspi_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDRESS_WIDTH  = QSPI_ADDRESS_WIDTH,
  parameter int unsigned COMMAND_WIDTH  = QSPI_COMMAND_WIDTH,
  parameter int unsigned DATA_WIDTH     = QSPI_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic [NUM_REQ*COMMAND_WIDTH-1:0]   i_req_cmd,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_wdata,
  output logic [NUM_REQ-1:0]                 o_rsp_valid,
  output logic [DATA_WIDTH-1:0]              o_rsp_data,
  output logic                               o_rsp_err,
  output logic [ID_WIDTH-1:0]                o_grant_id,
  output logic                               o_ctl_start,
  output logic [COMMAND_WIDTH-1:0]           o_ctl_command,
  output logic [ADDRESS_WIDTH-1:0]           o_ctl_address,
  output logic [DATA_WIDTH-1:0]              o_ctl_data_in,
  input  logic [DATA_WIDTH-1:0]              i_ctl_data_out,
  input  logic                               i_ctl_busy,
  input  logic                               i_ctl_done
);

  logic [1:0]               r_state;
  logic [ID_WIDTH-1:0]      r_last;
  logic [ID_WIDTH-1:0]      r_grant_id;
  logic [COMMAND_WIDTH-1:0] r_cmd;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_err;

  logic [NUM_REQ-1:0]       w_grant;
  logic [ID_WIDTH-1:0]      w_win_id;
  logic                     w_any;
  logic                     w_timeout;

  logic [COMMAND_WIDTH-1:0] w_cmd   [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_cmd[g]   = i_req_cmd[g*COMMAND_WIDTH +: COMMAND_WIDTH];
    assign w_addr[g]  = i_req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_wdata[g] = i_req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  qspi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_valid    (i_req_valid),
    .i_last     (r_last),
    .o_grant    (w_grant),
    .o_grant_id (w_win_id),
    .o_any      (w_any)
  );

  // Busy is informational only; the FSM never starts the controller mid-transaction.
  logic w_unused_busy;
  assign w_unused_busy = i_ctl_busy;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] r_timer;

  // The counter holds the number of WAIT cycles already elapsed. Hitting the last value
  // means the current cycle is the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
    end else if (r_state == ARB_ISSUE) begin
      r_timer <= '0;
    end else if (r_state == ARB_WAIT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_timer == TIMER_LAST);
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_last     <= ID_WIDTH'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state    <= ARB_ISSUE;
            r_grant_id <= w_win_id;
            r_cmd      <= w_cmd[w_win_id];
            r_addr     <= w_addr[w_win_id];
            r_wdata    <= w_wdata[w_win_id];
          end
        end
        ARB_ISSUE: r_state <= ARB_WAIT;
        ARB_WAIT: begin
          // Done wins over a coincident timeout.
          if (i_ctl_done) begin
            r_state    <= ARB_RESP;
            r_rsp_data <= i_ctl_data_out;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_state    <= ARB_RESP;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
          r_last  <= r_grant_id;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_req_ready   = (r_state == ARB_IDLE) ? w_grant : '0;
  assign o_ctl_start   = (r_state == ARB_ISSUE);
  assign o_rsp_valid   = (r_state == ARB_RESP) ?
                         ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id) : '0;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_err     = r_rsp_err;
  assign o_grant_id    = r_grant_id;
  assign o_ctl_command = r_cmd;
  assign o_ctl_address = r_addr;
  assign o_ctl_data_in = r_wdata;

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Directed bench for qspi_flash_arbiter (two requesters, default widths).
// The controller model raises done three cycles after start when enabled. The timeout
// scenario runs only when QSPI_ARB_TIMEOUT_EN is defined.
module tb_qspi_flash_arbiter;
  import qspi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_cmd = '0;
  logic [63:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [3:0]  rsp_data;
  logic        rsp_err;
  logic [0:0]  grant_id;
  logic        ctl_start;
  logic [7:0]  ctl_command;
  logic [31:0] ctl_address;
  logic [3:0]  ctl_data_in;
  logic [3:0]  ctl_data_out = '0;
  logic        ctl_busy;
  logic        ctl_done;
  logic        model_done;
  logic        spur_done = 1'b0;
  logic        model_en = 1'b0;
  logic [1:0]  model_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int outst = 0;
  int max_outst = 0;
  int t_a, t_b;
  int t_rsp [3];

  always #5 clk = ~clk;

  qspi_flash_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_cmd      (req_cmd),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_err      (rsp_err),
    .o_grant_id     (grant_id),
    .o_ctl_start    (ctl_start),
    .o_ctl_command  (ctl_command),
    .o_ctl_address  (ctl_address),
    .o_ctl_data_in  (ctl_data_in),
    .i_ctl_data_out (ctl_data_out),
    .i_ctl_busy     (ctl_busy),
    .i_ctl_done     (ctl_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: done is high in the third cycle after the start cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_cnt  <= '0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (model_en && ctl_start) begin
        model_cnt <= 2'd2;
      end else if (model_cnt != 0) begin
        model_cnt <= model_cnt - 1'b1;
        if (model_cnt == 2'd1) model_done <= 1'b1;
      end
    end
  end
  assign ctl_busy = (model_cnt != 0);
  assign ctl_done = model_done | spur_done;

  // Outstanding-transaction tracker: starts minus responses.
  always @(negedge clk) begin
    if (!reset_n) begin
      outst <= 0;
    end else begin
      outst <= outst + (ctl_start ? 1 : 0) - ((rsp_valid != 0) ? 1 : 0);
      if (outst > max_outst) max_outst <= outst;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (!ctl_start && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {63'd0, ctl_start}, 64'd1);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] exp);
    int k = 0;
    while (rsp_valid == 2'b00 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {62'd0, rsp_valid}, {62'd0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
    chk({tag, "_rspv"}, {62'd0, rsp_valid}, 64'd0);
    chk({tag, "_rspd"}, {60'd0, rsp_data}, 64'd0);
    chk({tag, "_err"}, {63'd0, rsp_err}, 64'd0);
    chk({tag, "_gid"}, {63'd0, grant_id}, 64'd0);
    chk({tag, "_start"}, {63'd0, ctl_start}, 64'd0);
    chk({tag, "_cmd"}, {56'd0, ctl_command}, 64'd0);
    chk({tag, "_addr"}, {32'd0, ctl_address}, 64'd0);
    chk({tag, "_din"}, {60'd0, ctl_data_in}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Single request from requester 0
    @(negedge clk);
    req_cmd[7:0]   = 8'h0B;
    req_addr[31:0] = 32'h0000_1000;
    req_wdata[3:0] = 4'hA;
    ctl_data_out   = 4'h5;
    model_en       = 1'b1;
    req_valid      = 2'b01;
    #1 chk("t1_ready", {62'd0, req_ready}, 64'h1);
    @(negedge clk);
    t_a = cyc;
    chk("t1_start", {63'd0, ctl_start}, 64'd1);
    chk("t1_cmd", {56'd0, ctl_command}, 64'h0B);
    chk("t1_addr", {32'd0, ctl_address}, 64'h1000);
    chk("t1_din", {60'd0, ctl_data_in}, 64'hA);
    chk("t1_gid", {63'd0, grant_id}, 64'd0);
    chk("t1_ready_issue", {62'd0, req_ready}, 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_start_1cyc", {63'd0, ctl_start}, 64'd0);
    wait_rsp("t1_rsp", 2'b01);
    chk("t1_latency", 64'(cyc - t_a), 64'd4);
    chk("t1_rdata", {60'd0, rsp_data}, 64'h5);
    chk("t1_err", {63'd0, rsp_err}, 64'd0);
    @(negedge clk);
    chk("t1_rsp_1cyc", {62'd0, rsp_valid}, 64'd0);
    chk("t1_rdata_hold", {60'd0, rsp_data}, 64'h5);

    // Contention from reset: grants alternate 0,1,0,1
    reset_n   = 1'b0;
    req_cmd   = {8'h22, 8'h11};
    req_addr  = {32'h2000_0000, 32'h1000_0000};
    req_wdata = {4'h2, 4'h1};
    req_valid = 2'b11;
    ctl_data_out = 4'hC;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start("t2_start");
      chk("t2_gid", {63'd0, grant_id}, 64'(i % 2));
      chk("t2_cmd", {56'd0, ctl_command}, (i % 2 == 1) ? 64'h22 : 64'h11);
      chk("t2_addr", {32'd0, ctl_address}, (i % 2 == 1) ? 64'h2000_0000 : 64'h1000_0000);
      wait_rsp("t2_rsp", (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    req_valid = 2'b00;

    // Lone requester 1, three back-to-back transactions
    @(negedge clk);
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      wait_start("t3_start");
      chk("t3_gid", {63'd0, grant_id}, 64'd1);
      wait_rsp("t3_rsp", 2'b10);
      t_rsp[i] = cyc;
    end
    req_valid = 2'b00;
    chk("t3_gap01", 64'(t_rsp[1] - t_rsp[0]), 64'd6);
    chk("t3_gap12", 64'(t_rsp[2] - t_rsp[1]), 64'd6);

    // Spurious done in IDLE and ISSUE
    model_en = 1'b0;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("t4_idle_rspv", {62'd0, rsp_valid}, 64'd0);
    chk("t4_idle_start", {63'd0, ctl_start}, 64'd0);
    ctl_data_out = 4'h9;
    req_valid = 2'b01;
    wait_start("t4_start");
    spur_done = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    spur_done = 1'b0;
    chk("t4_issue_done_ignored", {62'd0, rsp_valid}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_wait_hold", {62'd0, rsp_valid}, 64'd0);
    end
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("t4_rsp", {62'd0, rsp_valid}, 64'h1);
    chk("t4_rdata", {60'd0, rsp_data}, 64'h9);

    // Reset two cycles after start; requester 0 has priority afterwards
    model_en = 1'b1;
    ctl_data_out = 4'h3;
    @(negedge clk);
    req_valid = 2'b10;
    wait_start("t5_start");
    chk("t5_gid", {63'd0, grant_id}, 64'd1);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1 chk_all_zero("t5_rst");
    @(negedge clk);
    chk("t5_no_rsp", {62'd0, rsp_valid}, 64'd0);
    reset_n = 1'b1;
    req_valid = 2'b11;
    wait_start("t5_start2");
    chk("t5_gid_after_rst", {63'd0, grant_id}, 64'd0);
    req_valid = 2'b00;
    wait_rsp("t5_rsp", 2'b01);
    chk("t5_rdata", {60'd0, rsp_data}, 64'h3);

`ifdef QSPI_ARB_TIMEOUT_EN
    // Watchdog: no done, response after 8 WAIT cycles with err=1 and data=0
    model_en = 1'b0;
    ctl_data_out = 4'h7;
    @(negedge clk);
    req_valid = 2'b01;
    wait_start("t6_start");
    t_b = cyc;
    req_valid = 2'b00;
    wait_rsp("t6_rsp", 2'b01);
    chk("t6_latency", 64'(cyc - t_b), 64'd9);
    chk("t6_err", {63'd0, rsp_err}, 64'd1);
    chk("t6_rdata", {60'd0, rsp_data}, 64'd0);
    model_en = 1'b1;
    @(negedge clk);
    req_valid = 2'b01;
    wait_start("t6_start2");
    req_valid = 2'b00;
    wait_rsp("t6_rsp2", 2'b01);
    chk("t6_err2", {63'd0, rsp_err}, 64'd0);
    chk("t6_rdata2", {60'd0, rsp_data}, 64'h7);
`endif

    @(negedge clk);
    chk("max_outstanding", 64'(max_outst), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_flash_arbiter.md
Name: qspi_flash_arbiter

Overview:
- Shares one qspi_spi_controller instance between NUM_REQ requesters, for example instruction fetch and a data/config port.
- Arbitrates round-robin, latches the winner's command/address/data, and drives the controller's start/command/address/data_in.
- Waits for the controller's done pulse, then returns data_out to the granted requester as a one-cycle response.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDRESS_WIDTH, 32, address width; matches the controller.
- COMMAND_WIDTH, 8, command width; matches the controller.
- DATA_WIDTH, 4, data width; matches the controller.
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; see interface decision below
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_cmd  in  NUM_REQ*COMMAND_WIDTH  packed commands; requester i at [i*COMMAND_WIDTH +: COMMAND_WIDTH]
- req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- rsp_valid  out  NUM_REQ  one-hot response pulse
- rsp_data  out  DATA_WIDTH  response data, shared by all requesters
- rsp_err  out  1  timeout flag, valid with rsp_valid
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner
- ctl_start  out  1  start pulse to the controller
- ctl_command  out  COMMAND_WIDTH  latched command
- ctl_address  out  ADDRESS_WIDTH  latched address
- ctl_data_in  out  DATA_WIDTH  latched write data
- ctl_data_out  in  DATA_WIDTH  controller read data
- ctl_busy  in  1  controller busy (informational; must be 0 when start is issued)
- ctl_done  in  1  controller done pulse

Behaviour:
- Interface decision: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - state=IDLE.
  - All outputs 0, including req_ready, rsp_valid, rsp_data, rsp_err, ctl_start, ctl_command, ctl_address, ctl_data_in and grant_id.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM:
  - IDLE → ISSUE on req_valid & req_ready.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP on ctl_done.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - Winner = first asserted req_valid scanning last+1, last+2, … modulo NUM_REQ.
  - req_ready is combinational, high only in IDLE, and one-hot to the winner.
  - Acceptance happens on the clock edge with req_valid & req_ready. On that edge, latch cmd/addr/wdata into the ctl_* registers and load grant_id.
- req_ready is 0 in ISSUE, WAIT and RESP; at most one transaction is outstanding.
- Requester contract: once req_valid is raised, it stays high with stable payload until accepted. The arbiter does not check this.
- ISSUE: ctl_start=1 for exactly one cycle. ctl_command, ctl_address and ctl_data_in stay stable from acceptance until return to IDLE.
- WAIT:
  - The cycle ctl_done=1 captures ctl_data_out into rsp_data.
  - ctl_done outside WAIT is ignored.
  - ctl_done in the same cycle as entering WAIT is honoured.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle; no back-pressure on the response.
  - last ← grant_id.
  - rsp_data holds its value until the next capture.
- Latency: acceptance at edge T gives ctl_start high in cycle T+1. rsp_valid is high one cycle after the ctl_done cycle.
- Minimum spacing between acceptances is 4 cycles plus the controller's duration.
- Simultaneous requests: strict rotation. With all requesters valid continuously, grants are 0,1,…,NUM_REQ-1,0,…
- A lone requester is re-granted every transaction.
- Reset mid-operation: returns immediately to IDLE with all outputs 0.
  - No rsp_valid is issued for the aborted transaction.
  - The pointer resets, so requester 0 has priority.

Optional Feature:
- Macro: QSPI_ARB_TIMEOUT_EN.
- With the macro defined:
  - An up-counter clears on entry to WAIT and counts every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ctl_done, go to RESP with rsp_err=1 and rsp_data=0.
  - A normal completion gives rsp_err=0.
  - ctl_done in the same cycle the limit is reached counts as success.
- Without the macro: no counter; rsp_err is tied 0; WAIT lasts until ctl_done.

Decomposition:
- Shared package/header qspi_pkg:
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP (2-bit).
  - Default ADDRESS_WIDTH, COMMAND_WIDTH and DATA_WIDTH constants, also used by the controller.
- One sub-module, qspi_rr_arbiter:
  - Pure combinational round-robin pick from req_valid and last.
  - Outputs a one-hot grant and an index.
  - The pointer register stays in the parent.

Test Plan:
- Single request, controller model with done 3 cycles after start: req_valid[0] with cmd 8'h0B, addr 32'h0000_1000, wdata 4'hA. Expect req_ready[0] for 1 cycle, ctl_start 1 cycle later with those values, then rsp_valid[0] one cycle after done with rsp_data = model's data_out.
- Contention: req_valid=2'b11 held from reset. Expect grants 0,1,0,1 and never two outstanding starts.
- Back-to-back single requester: req_valid[1] held for 3 transactions. Expect 3 grants to requester 1 and 3 rsp_valid[1] pulses, each at least 4 cycles apart.
- Spurious done: pulse ctl_done in IDLE and ISSUE. Expect no state change and no rsp_valid.
- Reset mid-WAIT: assert reset_n=0 two cycles after ctl_start. Expect all outputs 0 and no response. The next simultaneous request is granted to requester 0.
- With QSPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the controller never sends done. Expect rsp_valid with rsp_err=1 and rsp_data=0 exactly 8 WAIT cycles after entry. A later normal transaction gives rsp_err=0.
